// File: rtl/fibo_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : fibo_pkg                                                    |
// | Brief    : Shared state encoding and default sizes for fibo_sequencer |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package fibo_pkg;

  localparam int FIBO_WIDTH = 4;
  localparam int FIBO_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } fibo_state_e;

endpackage
`default_nettype wire

// File: rtl/fibo_adder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : fibo_adder                                                  |
// | Brief    : WIDTH-bit unsigned adder with carry-out                     |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module fibo_adder
  import fibo_pkg::*;
#(
  parameter int WIDTH = FIBO_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule
`default_nettype wire

// File: rtl/fibo_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : fibo_sequencer                                              |
// | Brief    : Emits Count Fibonacci terms over a Valid/Ack handshake     |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module fibo_sequencer
  import fibo_pkg::*;
#(
  parameter int WIDTH = FIBO_WIDTH,
  parameter int CNT_W = FIBO_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  output logic [WIDTH-1:0] Term,
  output logic             Valid,
  input  logic             Ack,
  output logic             Busy,
  output logic             Done,
  output logic             Overflow
);

  fibo_state_e      r_state;
  fibo_state_e      w_state_nxt;

  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_nxt;
  logic             r_ovf_pend;
  logic [CNT_W-1:0] r_emitted;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_last;

  logic             w_load;
  logic             w_clr_ovf;
  logic             w_advance;
  logic             w_set_ovf;

  fibo_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .i_a     (r_cur),
    .i_b     (r_nxt),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // r_count is never zero while in EMIT, so the decrement cannot wrap.
  assign w_last = (r_emitted == (r_count - CNT_W'(1)));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clr_ovf   = 1'b0;
    w_advance   = 1'b0;
    w_set_ovf   = 1'b0;
    Valid       = 1'b0;
    Busy        = 1'b1;
    Done        = 1'b0;

    unique case (r_state)
      IDLE: begin
        Busy = 1'b0;
        if (Start) begin
          w_clr_ovf = 1'b1;
          if (Count != '0) begin
            w_load      = 1'b1;
            w_state_nxt = EMIT;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      EMIT: begin
        Valid = 1'b1;
        if (Ack) begin
          // Reaching the requested count wins over a pending overflow.
          if (w_last) begin
            w_state_nxt = DONE;
          end else if (r_ovf_pend) begin
            w_set_ovf   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      DONE: begin
        Done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cur      <= '0;
      r_nxt      <= '0;
      r_ovf_pend <= 1'b0;
      r_emitted  <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_clr_ovf) begin
        r_overflow <= 1'b0;
      end else if (w_set_ovf) begin
        r_overflow <= 1'b1;
      end

      if (w_load) begin
        r_count    <= Count;
        r_cur      <= '0;
        r_nxt      <= WIDTH'(1);
        r_emitted  <= '0;
        r_ovf_pend <= 1'b0;
      end else if (w_advance) begin
        // ovf_pend flags that the term now moving into nxt has wrapped.
        r_cur      <= r_nxt;
        r_nxt      <= w_sum;
        r_ovf_pend <= w_carry;
        r_emitted  <= r_emitted + CNT_W'(1);
      end
    end
  end

  assign Term     = r_cur;
  assign Overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fibo_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_fibo_sequencer                                           |
// | Brief    : Self-checking bench with an arithmetic Fibonacci model      |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module tb_fibo_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             Start = 1'b0;
  logic [CNT_W-1:0] Count = '0;
  logic             Ack = 1'b0;
  logic [WIDTH-1:0] Term;
  logic             Valid;
  logic             Busy;
  logic             Done;
  logic             Overflow;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  bit exp_ovf;
  bit model_ovf = 1'b0;
  int last_term = 0;

  fibo_sequencer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Start    (Start),
    .Count    (Count),
    .Term     (Term),
    .Valid    (Valid),
    .Ack      (Ack),
    .Busy     (Busy),
    .Done     (Done),
    .Overflow (Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Terms are plain Fibonacci numbers; the run stops early once a term no longer fits.
  function automatic void build_model(input int cnt);
    int a, b, t;
    exp_q.delete();
    exp_ovf = 1'b0;
    a = 0;
    b = 1;
    for (int k = 0; k < cnt; k++) begin
      if (a >= (1 << WIDTH)) begin
        exp_ovf = 1'b1;
        break;
      end
      exp_q.push_back(a);
      t = a + b;
      a = b;
      b = t;
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_seq(input int cnt, input int ack_pct, input bit noise, input int stall_term);
    int idx;
    int cycles;
    int stalls;
    check("idle_busy", Busy, 0);
    check("idle_valid", Valid, 0);
    check("idle_ovf", Overflow, model_ovf);
    build_model(cnt);
    Start = 1'b1;
    Count = CNT_W'(cnt);
    @(negedge Clk);
    Start = 1'b0;
    model_ovf = 1'b0;
    if (cnt == 0) begin
      check("z_valid", Valid, 0);
      check("z_done", Done, 1);
      check("z_busy", Busy, 1);
      check("z_ovf", Overflow, 0);
      check("z_term", Term, last_term);
      @(negedge Clk);
      check("z_done_end", Done, 0);
      check("z_busy_end", Busy, 0);
      return;
    end
    idx = 0;
    cycles = 0;
    stalls = 0;
    while (idx < exp_q.size()) begin
      check("emit_valid", Valid, 1);
      check("emit_term", Term, exp_q[idx]);
      check("emit_done", Done, 0);
      check("emit_ovf", Overflow, 0);
      if (exp_q[idx] == stall_term && stalls < 3) begin
        Ack = 1'b0;
        Start = 1'b1;
        Count = CNT_W'(1);
        stalls++;
      end else begin
        Ack = ($urandom_range(0, 99) < ack_pct);
        Start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        Count = CNT_W'($urandom);
      end
      if (Ack) idx++;
      @(negedge Clk);
      cycles++;
      if (cycles > 400) begin
        check("timeout", 0, 1);
        break;
      end
    end
    Ack = 1'b0;
    Start = 1'b0;
    last_term = exp_q[exp_q.size() - 1];
    model_ovf = exp_ovf;
    check("end_done", Done, 1);
    check("end_valid", Valid, 0);
    check("end_ovf", Overflow, model_ovf);
    check("end_term", Term, last_term);
    @(negedge Clk);
    check("post_done", Done, 0);
    check("post_busy", Busy, 0);
    check("post_ovf", Overflow, model_ovf);
    check("post_term", Term, last_term);
  endtask

  initial begin
    #12;
    check("rst_term", Term, 0);
    check("rst_valid", Valid, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_ovf", Overflow, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    run_seq(7, 100, 1'b0, -1);
    run_seq(10, 100, 1'b0, -1);
    repeat (3) @(negedge Clk);
    check("ovf_sticky", Overflow, 1);
    run_seq(8, 100, 1'b0, -1);
    run_seq(10, 100, 1'b0, -1);
    run_seq(0, 100, 1'b0, -1);
    run_seq(7, 100, 1'b0, 2);

    // Reset mid-sequence while Term=5.
    Start = 1'b1;
    Count = CNT_W'(7);
    Ack = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("pre_rst_term", Term, (i < 2) ? i : ((i == 2) ? 1 : ((i == 3) ? 2 : ((i == 4) ? 3 : 5))));
      if (i < 5) @(negedge Clk);
    end
    Reset_n = 1'b0;
    Ack = 1'b0;
    #1;
    check("arst_term", Term, 0);
    check("arst_valid", Valid, 0);
    check("arst_busy", Busy, 0);
    check("arst_done", Done, 0);
    check("arst_ovf", Overflow, 0);
    @(negedge Clk);
    check("arst_nodone", Done, 0);
    Reset_n = 1'b1;
    model_ovf = 1'b0;
    last_term = 0;
    run_seq(3, 100, 1'b0, -1);

    for (int n = 0; n < 10; n++) begin
      run_seq($urandom_range(0, 15), $urandom_range(30, 100), 1'b1, -1);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fibo_sequencer.md
FIBO_SEQUENCER -- requirements
Module: fibo_sequencer

Interface
REQ-001 Parameter: WIDTH, default 4, data width of each emitted term.
REQ-002 Parameter: CNT_W, default 4, width of the requested term count.
REQ-003 Port: Clk, input, 1, single clock; all state changes on rising edge.
REQ-004 Port: Reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port: Start, input, 1, request a new sequence; sampled only in IDLE.
REQ-006 Port: Count, input, CNT_W, number of terms requested; latched when Start is accepted.
REQ-007 Port: Term, output, WIDTH, current Fibonacci term.
REQ-008 Port: Valid, output, 1, Term holds a term not yet transferred.
REQ-009 Port: Ack, input, 1, consumer accepts Term; a transfer occurs on an edge with Valid=1 and Ack=1.
REQ-010 Port: Busy, output, 1, high in every state except IDLE.
REQ-011 Port: Done, output, 1, one-cycle pulse when a sequence ends.
REQ-012 Port: Overflow, output, 1, sticky flag: the sequence was cut short by WIDTH overflow.

Function
REQ-013 States SHALL be IDLE, EMIT, DONE; DONE always returns to IDLE after one cycle.
REQ-014 Internal registers SHALL be cur (WIDTH), nxt (WIDTH), ovf_pend (1) and emitted (CNT_W).
REQ-015 IDLE with Start=1, Count!=0:
- latch Count
- cur<=0, nxt<=1, emitted<=0, Overflow<=0, ovf_pend<=0
- go to EMIT; Valid=1 and Term=0 in the following cycle.
REQ-016 IDLE with Start=1, Count=0: clear Overflow and go to DONE; Valid is never asserted.
REQ-017 In EMIT, Term SHALL equal cur and Valid SHALL be 1; Term stays stable while Ack=0.
REQ-018 On a transfer with emitted==Count-1, the block SHALL go to DONE; Overflow is unchanged, because count completion has priority.
REQ-019 On a transfer with ovf_pend=1 and emitted!=Count-1, the block SHALL set Overflow=1 and go to DONE.
REQ-020 On any other transfer, the block SHALL:
- set cur<=nxt and nxt<=(cur+nxt) mod 2^WIDTH
- set ovf_pend<=carry-out of cur+nxt
- increment emitted and stay in EMIT, with Valid remaining 1 (back-to-back, no bubble).
REQ-021 Start SHALL be ignored outside IDLE.
REQ-022 Done SHALL be 1 exactly in the DONE state; Valid SHALL be 0 in IDLE and DONE.
REQ-023 Term SHALL hold its last value outside EMIT.
REQ-024 Throughput SHALL be one term per cycle when Ack is held high.

Reset
REQ-025 Reset_n=0 SHALL force, asynchronously and regardless of state: state=IDLE, Term=0, Valid=0, Busy=0, Done=0, Overflow=0, cur=0, nxt=0, ovf_pend=0, emitted=0.
REQ-026 Reset asserted mid-sequence SHALL abandon the sequence with no Done pulse.
REQ-027 After release, the block SHALL accept Start on the first rising edge.

Structure
REQ-028 A shared package fibo_pkg SHALL hold the state enumeration and the default WIDTH/CNT_W constants.
REQ-029 One sub-module, fibo_adder (WIDTH-bit adder with carry-out), SHALL compute cur+nxt; all other logic is in fibo_sequencer.

Verification (WIDTH=4, CNT_W=4)
REQ-030 Start, Count=7, Ack=1 -> Terms 0,1,1,2,3,5,8 on 7 consecutive cycles, then Done one cycle, Overflow=0.
REQ-031 Start, Count=10, Ack=1 -> Terms 0,1,1,2,3,5,8,13, then Done with Overflow=1; Overflow holds until the next accepted Start.
REQ-032 Start, Count=8 -> 8 terms ending at 13, Done, Overflow=0 (count-completion priority).
REQ-033 Start, Count=0 -> Done the cycle after Start, Valid never 1, Busy high for one cycle.
REQ-034 Ack low for 3 cycles while Term=2 -> Term stays 2 and Valid stays 1; Start pulsed meanwhile is ignored; the sequence resumes with 3 on Ack.
REQ-035 Reset_n pulsed low while Term=5 -> all outputs 0 immediately, no Done; a new Start with Count=3 yields 0,1,1.
